// File: rtl/ctrl_pipeline.sv
// Pipelined MIPS control unit: ID decode, ID/EX -> MEM/WB control registers, RAW stall and branch flush.
// Build option: define CTRL_FWD_EN for the forwarding unit (stall only on load-use).
module ctrl_pipeline #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALUOP_W    = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [5:0]            id_opcode_i,
    input  logic [5:0]            id_func_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  ex_zero_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  pc_src_o,
    output logic [ALUOP_W-1:0]    ex_alu_op_o,
    output logic                  ex_alu_src_o,
    output logic [1:0]            forward_a_o,
    output logic [1:0]            forward_b_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [REG_ADDR_W-1:0] mem_wreg_o,
    output logic [REG_ADDR_W-1:0] wb_wreg_o,
    output logic                  wb_reg_write_o,
    output logic                  wb_mem_to_reg_o,
    output logic                  illegal_op_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;

    localparam logic [ALUOP_W-1:0] AluAnd = ALUOP_W'(4'b0000);
    localparam logic [ALUOP_W-1:0] AluOr  = ALUOP_W'(4'b0001);
    localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(4'b0010);
    localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(4'b0110);
    localparam logic [ALUOP_W-1:0] AluSlt = ALUOP_W'(4'b0111);
    localparam logic [ALUOP_W-1:0] AluNor = ALUOP_W'(4'b1100);

    // ID decode
    logic [ALUOP_W-1:0]    id_alu_op;
    logic                  id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
    logic                  id_branch, id_bne, id_legal, id_rt_src;
    logic [REG_ADDR_W-1:0] id_wreg;

    // ID/EX
    logic [ALUOP_W-1:0]    ex_alu_op_q;
    logic                  ex_alu_src_q, ex_mem_read_q, ex_mem_write_q, ex_reg_write_q;
    logic                  ex_mem_to_reg_q, ex_branch_q, ex_bne_q;
    logic [REG_ADDR_W-1:0] ex_wreg_q;
    // EX/MEM
    logic                  mem_mem_read_q, mem_mem_write_q, mem_reg_write_q, mem_mem_to_reg_q;
    logic [REG_ADDR_W-1:0] mem_wreg_q;
    // MEM/WB
    logic                  wb_reg_write_q, wb_mem_to_reg_q;
    logic [REG_ADDR_W-1:0] wb_wreg_q;

    logic                  illegal_q;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic rs_src, rt_src, hit_ex, raw_hazard, branch_taken, stall, bubble;

    always_comb begin
        id_alu_op     = '0;
        id_alu_src    = 1'b0;
        id_mem_read   = 1'b0;
        id_mem_write  = 1'b0;
        id_reg_write  = 1'b0;
        id_mem_to_reg = 1'b0;
        id_branch     = 1'b0;
        id_bne        = 1'b0;
        id_legal      = 1'b1;
        id_rt_src     = 1'b0;
        id_wreg       = id_rt_i;
        case (id_opcode_i)
            OpRtype: begin
                id_reg_write = 1'b1;
                id_rt_src    = 1'b1;
                id_wreg      = id_rd_i;
                case (id_func_i)
                    6'b100000: id_alu_op = AluAdd;
                    6'b100010: id_alu_op = AluSub;
                    6'b100100: id_alu_op = AluAnd;
                    6'b100101: id_alu_op = AluOr;
                    6'b100111: id_alu_op = AluNor;
                    6'b101010: id_alu_op = AluSlt;
                    default:   id_alu_op = AluAnd;
                endcase
            end
            OpLw: begin
                id_alu_op     = AluAdd;
                id_alu_src    = 1'b1;
                id_mem_read   = 1'b1;
                id_reg_write  = 1'b1;
                id_mem_to_reg = 1'b1;
            end
            OpSw: begin
                id_alu_op    = AluAdd;
                id_alu_src   = 1'b1;
                id_mem_write = 1'b1;
                id_rt_src    = 1'b1;
            end
            OpBeq: begin
                id_alu_op = AluSub;
                id_branch = 1'b1;
                id_rt_src = 1'b1;
            end
            OpBne: begin
                id_alu_op = AluSub;
                id_branch = 1'b1;
                id_bne    = 1'b1;
                id_rt_src = 1'b1;
            end
            OpAddi: begin
                id_alu_op    = AluAdd;
                id_alu_src   = 1'b1;
                id_reg_write = 1'b1;
            end
            default: begin
                id_legal = 1'b0;
                id_wreg  = '0;
            end
        endcase
    end

    // A non-zero source excludes reg 0 from ever matching a destination.
    assign rs_src = id_legal && (id_rs_i != '0);
    assign rt_src = id_rt_src && (id_rt_i != '0);
    assign hit_ex = (rs_src && (id_rs_i == ex_wreg_q)) || (rt_src && (id_rt_i == ex_wreg_q));

`ifdef CTRL_FWD_EN
    logic [REG_ADDR_W-1:0] ex_rs_q, ex_rt_q;

    assign raw_hazard = ex_mem_read_q && hit_ex;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || bubble) begin
            ex_rs_q <= '0;
            ex_rt_q <= '0;
        end else begin
            ex_rs_q <= id_rs_i;
            ex_rt_q <= id_rt_i;
        end
    end

    always_comb begin
        forward_a_o = 2'b00;
        forward_b_o = 2'b00;
        if (mem_reg_write_q && (mem_wreg_q != '0) && (mem_wreg_q == ex_rs_q)) begin
            forward_a_o = 2'b10;
        end else if (wb_reg_write_q && (wb_wreg_q != '0) && (wb_wreg_q == ex_rs_q)) begin
            forward_a_o = 2'b01;
        end
        if (mem_reg_write_q && (mem_wreg_q != '0) && (mem_wreg_q == ex_rt_q)) begin
            forward_b_o = 2'b10;
        end else if (wb_reg_write_q && (wb_wreg_q != '0) && (wb_wreg_q == ex_rt_q)) begin
            forward_b_o = 2'b01;
        end
    end
`else
    logic hit_mem;

    // WB needs no check: the register file writes before it is read.
    assign hit_mem    = (rs_src && (id_rs_i == mem_wreg_q)) || (rt_src && (id_rt_i == mem_wreg_q));
    assign raw_hazard = (ex_reg_write_q && hit_ex) || (mem_reg_write_q && hit_mem);
    assign forward_a_o = 2'b00;
    assign forward_b_o = 2'b00;
`endif

    assign branch_taken = ex_branch_q && (ex_bne_q ? !ex_zero_i : ex_zero_i);
    assign stall        = raw_hazard && !branch_taken;
    assign bubble       = raw_hazard || branch_taken;

    assign pc_write_o   = !stall;
    assign ifid_write_o = !stall;
    assign ifid_flush_o = branch_taken;
    assign pc_src_o     = branch_taken;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ex_alu_op_q      <= '0;
            ex_alu_src_q     <= 1'b0;
            ex_mem_read_q    <= 1'b0;
            ex_mem_write_q   <= 1'b0;
            ex_reg_write_q   <= 1'b0;
            ex_mem_to_reg_q  <= 1'b0;
            ex_branch_q      <= 1'b0;
            ex_bne_q         <= 1'b0;
            ex_wreg_q        <= '0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            mem_wreg_q       <= '0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= 1'b0;
            wb_wreg_q        <= '0;
            illegal_q        <= 1'b0;
            stall_cnt_q      <= '0;
            flush_cnt_q      <= '0;
        end else begin
            if (bubble) begin
                ex_alu_op_q     <= '0;
                ex_alu_src_q    <= 1'b0;
                ex_mem_read_q   <= 1'b0;
                ex_mem_write_q  <= 1'b0;
                ex_reg_write_q  <= 1'b0;
                ex_mem_to_reg_q <= 1'b0;
                ex_branch_q     <= 1'b0;
                ex_bne_q        <= 1'b0;
                ex_wreg_q       <= '0;
            end else begin
                ex_alu_op_q     <= id_alu_op;
                ex_alu_src_q    <= id_alu_src;
                ex_mem_read_q   <= id_mem_read;
                ex_mem_write_q  <= id_mem_write;
                ex_reg_write_q  <= id_reg_write;
                ex_mem_to_reg_q <= id_mem_to_reg;
                ex_branch_q     <= id_branch;
                ex_bne_q        <= id_bne;
                ex_wreg_q       <= id_wreg;
            end
            mem_mem_read_q   <= ex_mem_read_q;
            mem_mem_write_q  <= ex_mem_write_q;
            mem_reg_write_q  <= ex_reg_write_q;
            mem_mem_to_reg_q <= ex_mem_to_reg_q;
            mem_wreg_q       <= ex_wreg_q;
            wb_reg_write_q   <= mem_reg_write_q;
            wb_mem_to_reg_q  <= mem_mem_to_reg_q;
            wb_wreg_q        <= mem_wreg_q;
            // A flushed illegal instruction never leaves ID, so it does not report.
            illegal_q        <= !id_legal && !bubble;
            stall_cnt_q      <= stall_cnt_d;
            flush_cnt_q      <= flush_cnt_d;
        end
    end

    assign ex_alu_op_o     = ex_alu_op_q;
    assign ex_alu_src_o    = ex_alu_src_q;
    assign mem_read_o      = mem_mem_read_q;
    assign mem_write_o     = mem_mem_write_q;
    assign mem_wreg_o      = mem_wreg_q;
    assign wb_wreg_o       = wb_wreg_q;
    assign wb_reg_write_o  = wb_reg_write_q;
    assign wb_mem_to_reg_o = wb_mem_to_reg_q;
    assign illegal_op_o    = illegal_q;
    assign stall_cnt_o     = stall_cnt_q;
    assign flush_cnt_o     = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed scenarios then random instruction stream against a queue model.
// Honours CTRL_FWD_EN the same way as the design.
module tb_ctrl_pipeline;

    localparam int unsigned RW  = 5;
    localparam int unsigned AW  = 4;
    localparam int unsigned CW  = 4;
    localparam int          SAT = (1 << CW) - 1;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] FADD = 6'b100000;
    localparam logic [5:0] FSUB = 6'b100010;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    id_opcode, id_func;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic          ex_zero;
    logic          pc_write, ifid_write, ifid_flush, pc_src, ex_alu_src;
    logic [AW-1:0] ex_alu_op;
    logic [1:0]    forward_a, forward_b;
    logic          mem_read, mem_write, wb_reg_write, wb_mem_to_reg, illegal_op;
    logic [RW-1:0] mem_wreg, wb_wreg;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    ctrl_pipeline #(.REG_ADDR_W(RW), .ALUOP_W(AW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .id_opcode_i(id_opcode), .id_func_i(id_func),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd), .ex_zero_i(ex_zero),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
        .pc_src_o(pc_src), .ex_alu_op_o(ex_alu_op), .ex_alu_src_o(ex_alu_src),
        .forward_a_o(forward_a), .forward_b_o(forward_b), .mem_read_o(mem_read),
        .mem_write_o(mem_write), .mem_wreg_o(mem_wreg), .wb_wreg_o(wb_wreg),
        .wb_reg_write_o(wb_reg_write), .wb_mem_to_reg_o(wb_mem_to_reg),
        .illegal_op_o(illegal_op), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    // One in-flight instruction as seen by the later stages.
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, bne;
        logic [4:0] wreg, rs, rt;
    } slot_t;

    slot_t pipe [3];  // 0 = EX, 1 = MEM, 2 = WB
    slot_t m_id;
    logic  m_legal, m_rt_src, m_raw, m_stall, m_flush, m_illegal;
    logic [1:0] m_fa, m_fb;
    int    m_stall_cnt, m_flush_cnt;
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic slot_t decode(input logic [5:0] op, fn, input logic [4:0] rs, rt, rd,
                                     output logic legal, output logic rt_src);
        slot_t s;
        s = '0;
        s.rs = rs;
        s.rt = rt;
        legal = 1'b1;
        rt_src = 1'b0;
        if (op == R) begin
            s.reg_write = 1'b1;
            s.wreg = rd;
            rt_src = 1'b1;
            if (fn == 6'b100000) s.alu_op = 4'b0010;
            else if (fn == 6'b100010) s.alu_op = 4'b0110;
            else if (fn == 6'b100101) s.alu_op = 4'b0001;
            else if (fn == 6'b100111) s.alu_op = 4'b1100;
            else if (fn == 6'b101010) s.alu_op = 4'b0111;
            else s.alu_op = 4'b0000;
        end else if (op == LW) begin
            s = '{alu_op: 4'b0010, alu_src: 1, mem_read: 1, mem_write: 0, reg_write: 1,
                  mem_to_reg: 1, branch: 0, bne: 0, wreg: rt, rs: rs, rt: rt};
        end else if (op == SW) begin
            s = '{alu_op: 4'b0010, alu_src: 1, mem_read: 0, mem_write: 1, reg_write: 0,
                  mem_to_reg: 0, branch: 0, bne: 0, wreg: rt, rs: rs, rt: rt};
            rt_src = 1'b1;
        end else if (op == BEQ || op == BNE) begin
            s = '{alu_op: 4'b0110, alu_src: 0, mem_read: 0, mem_write: 0, reg_write: 0,
                  mem_to_reg: 0, branch: 1, bne: (op == BNE), wreg: rt, rs: rs, rt: rt};
            rt_src = 1'b1;
        end else if (op == ADDI) begin
            s = '{alu_op: 4'b0010, alu_src: 1, mem_read: 0, mem_write: 0, reg_write: 1,
                  mem_to_reg: 0, branch: 0, bne: 0, wreg: rt, rs: rs, rt: rt};
        end else begin
            legal = 1'b0;
        end
        return s;
    endfunction

    function automatic logic reads(input logic [4:0] w);
        return (w != 0) && ((m_legal && m_id.rs == w) || (m_rt_src && m_id.rt == w));
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] src);
        if (pipe[1].reg_write && pipe[1].wreg != 0 && pipe[1].wreg == src) return 2'b10;
        if (pipe[2].reg_write && pipe[2].wreg != 0 && pipe[2].wreg == src) return 2'b01;
        return 2'b00;
    endfunction

    // Apply ID inputs (called just after a rising edge) and check every output mid-cycle.
    task automatic drive(input logic [5:0] op, fn, input logic [4:0] rs, rt, rd,
                         input logic z, input logic rst);
        id_opcode = op; id_func = fn; id_rs = rs; id_rt = rt; id_rd = rd;
        ex_zero = z; rst_n = rst;
        m_id = decode(op, fn, rs, rt, rd, m_legal, m_rt_src);
        m_flush = pipe[0].branch && (pipe[0].bne ? !z : z);
`ifdef CTRL_FWD_EN
        m_raw = pipe[0].mem_read && reads(pipe[0].wreg);
        m_fa = fwd(pipe[0].rs);
        m_fb = fwd(pipe[0].rt);
`else
        m_raw = (pipe[0].reg_write && reads(pipe[0].wreg)) ||
                (pipe[1].reg_write && reads(pipe[1].wreg));
        m_fa = 2'b00;
        m_fb = 2'b00;
`endif
        m_stall = m_raw && !m_flush;
        #2;
        check("pc_write", pc_write, !m_stall);
        check("ifid_write", ifid_write, !m_stall);
        check("ifid_flush", ifid_flush, m_flush);
        check("pc_src", pc_src, m_flush);
        check("forward_a", forward_a, m_fa);
        check("forward_b", forward_b, m_fb);
        check("ex_alu_op", ex_alu_op, pipe[0].alu_op);
        check("ex_alu_src", ex_alu_src, pipe[0].alu_src);
        check("mem_read", mem_read, pipe[1].mem_read);
        check("mem_write", mem_write, pipe[1].mem_write);
        check("mem_wreg", mem_wreg, pipe[1].wreg);
        check("wb_reg_write", wb_reg_write, pipe[2].reg_write);
        check("wb_mem_to_reg", wb_mem_to_reg, pipe[2].mem_to_reg);
        check("wb_wreg", wb_wreg, pipe[2].wreg);
        check("illegal_op", illegal_op, m_illegal);
        check("stall_cnt", stall_cnt, m_stall_cnt);
        check("flush_cnt", flush_cnt, m_flush_cnt);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_illegal = 1'b0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (m_raw || m_flush) ? '0 : (m_legal ? m_id : slot_t'(0) | {25'd0, m_id.rs, m_id.rt});
            m_illegal = !m_legal && !(m_raw || m_flush);
            if (m_stall && m_stall_cnt < SAT) m_stall_cnt++;
            if (m_flush && m_flush_cnt < SAT) m_flush_cnt++;
        end
        #1;
    endtask

    task automatic step(input logic [5:0] op, fn, input logic [4:0] rs, rt, rd, input logic z);
        drive(op, fn, rs, rt, rd, z, 1'b1);
        tick();
    endtask

    task automatic do_reset();
        drive(R, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
    endtask

    logic [5:0] r_op, r_fn;
    logic [4:0] r_rs, r_rt, r_rd;
    logic       hold, flushed, r_rst;

    initial begin
        rst_n = 1'b0;
        id_opcode = R; id_func = 6'd0; id_rs = '0; id_rt = '0; id_rd = '0; ex_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // 1: add flows EX -> WB
        step(R, FADD, 5'd1, 5'd2, 5'd3, 1'b0);
        check("t1_ex_alu_op", ex_alu_op, 4'b0010);
        step(R, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        step(R, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("t1_wb_reg_write", wb_reg_write, 1);
        check("t1_wb_wreg", wb_wreg, 3);

        // 2: load-use
        do_reset();
        step(LW, 6'd0, 5'd1, 5'd8, 5'd0, 1'b0);
        drive(R, FADD, 5'd8, 5'd2, 5'd9, 1'b0, 1'b1);
        check("t2_stall1", pc_write, 0);
        tick();
`ifndef CTRL_FWD_EN
        drive(R, FADD, 5'd8, 5'd2, 5'd9, 1'b0, 1'b1);
        check("t2_stall2", pc_write, 0);
        tick();
`endif
        step(R, FADD, 5'd8, 5'd2, 5'd9, 1'b0);
        drive(R, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
`ifdef CTRL_FWD_EN
        check("t2_fwd_a", forward_a, 2'b01);
        check("t2_stall_cnt", stall_cnt, 1);
`else
        check("t2_stall_cnt", stall_cnt, 2);
`endif
        tick();

        // 3: ALU-ALU dependency, then reg 0 never a hazard
        do_reset();
        step(R, FADD, 5'd1, 5'd2, 5'd3, 1'b0);
        drive(R, FSUB, 5'd3, 5'd4, 5'd5, 1'b0, 1'b1);
`ifdef CTRL_FWD_EN
        check("t3_no_stall", pc_write, 1);
        tick();
        drive(R, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        check("t3_fwd_a", forward_a, 2'b10);
        tick();
`else
        check("t3_stall", pc_write, 0);
        tick();
        step(R, FSUB, 5'd3, 5'd4, 5'd5, 1'b0);
        step(R, FSUB, 5'd3, 5'd4, 5'd5, 1'b0);
        check("t3_stall_cnt", stall_cnt, 2);
`endif
        step(LW, 6'd0, 5'd1, 5'd0, 5'd0, 1'b0);
        drive(R, FADD, 5'd0, 5'd0, 5'd6, 1'b0, 1'b1);
        check("t3_reg0", pc_write, 1);
        tick();

        // 4: branches
        do_reset();
        step(BEQ, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
        drive(R, FADD, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1);
        check("t4_beq_pc_src", pc_src, 1);
        check("t4_beq_flush", ifid_flush, 1);
        tick();
        check("t4_bubble", ex_alu_op, 4'b0000);
        check("t4_flush_cnt", flush_cnt, 1);
        step(BNE, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
        drive(R, FADD, 5'd4, 5'd5, 5'd6, 1'b0, 1'b1);
        check("t4_bne_taken", pc_src, 1);
        tick();
        step(BNE, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
        drive(R, FADD, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1);
        check("t4_bne_not_taken", pc_src, 0);
        tick();

        // 5: illegal opcode, branch beats stall
        do_reset();
        step(6'b111111, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        check("t5_illegal_hi", illegal_op, 1);
        check("t5_illegal_ctl", ex_alu_op, 0);
        step(R, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("t5_illegal_lo", illegal_op, 0);
        step(ADDI, 6'd0, 5'd1, 5'd7, 5'd0, 1'b0);
        step(BEQ, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
        drive(R, FADD, 5'd7, 5'd0, 5'd9, 1'b1, 1'b1);
        check("t5_flush_beats_stall", pc_write, 1);
        tick();
        check("t5_stall_cnt", stall_cnt, 0);

        // 6: reset during stall, then counter saturation
        step(LW, 6'd0, 5'd1, 5'd8, 5'd0, 1'b0);
        drive(R, FADD, 5'd8, 5'd2, 5'd9, 1'b0, 1'b0);
        tick();
        drive(R, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        check("t6_pc_write", pc_write, 1);
        check("t6_stall_cnt", stall_cnt, 0);
        check("t6_mem_read", mem_read, 0);
        tick();
        for (int n = 0; n < 20; n++) begin
            step(LW, 6'd0, 5'd1, 5'd5, 5'd0, 1'b0);
            for (int k = 0; k < 4; k++) begin
                drive(R, FADD, 5'd5, 5'd0, 5'd6, 1'b0, 1'b1);
                tick();
                if (!m_stall) break;
            end
        end
        check("t6_stall_sat", stall_cnt, SAT);
        for (int n = 0; n < 20; n++) begin
            step(BEQ, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
            step(R, FADD, 5'd1, 5'd2, 5'd3, 1'b1);
            step(R, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        end
        check("t6_flush_sat", flush_cnt, SAT);

        // Random instruction stream; stalled instructions are held, flushed ones read as zero.
        do_reset();
        hold = 1'b0;
        flushed = 1'b0;
        r_op = R; r_fn = 6'd0; r_rs = '0; r_rt = '0; r_rd = '0;
        for (int i = 0; i < 800; i++) begin
            r_rst = ((i % 150) != 149);
            if (!hold) begin
                if (flushed) begin
                    r_op = R; r_fn = 6'd0; r_rs = '0; r_rt = '0; r_rd = '0;
                end else begin
                    case ($urandom_range(0, 9))
                        0, 1, 2: r_op = R;
                        3: r_op = LW;
                        4: r_op = SW;
                        5: r_op = BEQ;
                        6: r_op = BNE;
                        7: r_op = ADDI;
                        8: r_op = R;
                        default: r_op = ($urandom_range(0, 1) == 0) ? 6'b111111 : 6'b000010;
                    endcase
                    case ($urandom_range(0, 6))
                        0: r_fn = 6'b100000;
                        1: r_fn = 6'b100010;
                        2: r_fn = 6'b100100;
                        3: r_fn = 6'b100101;
                        4: r_fn = 6'b100111;
                        5: r_fn = 6'b101010;
                        default: r_fn = 6'b000011;
                    endcase
                    r_rs = 5'($urandom_range(0, 7));
                    r_rt = 5'($urandom_range(0, 7));
                    r_rd = 5'($urandom_range(0, 7));
                end
            end
            drive(r_op, r_fn, r_rs, r_rt, r_rd, 1'($urandom_range(0, 1)), r_rst);
            hold = m_stall && r_rst;
            flushed = m_flush && r_rst;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
